// File: rtl/pipelined_twiddle_mult_stream.sv
// Streaming FFT twiddle rotator: 3-multiplier complex product with fixed (C - jS), octant-selected
// symmetric reuse, four elastic valid/ready stages, tag sideband and sticky saturation flag.
module pipelined_twiddle_mult_stream #(
    parameter int unsigned          W        = 16,
    parameter int unsigned          CW       = 16,
    parameter int unsigned          FRAC     = 14,
    parameter int unsigned          TAG_W    = 6,
    parameter logic signed [CW-1:0] C_PLUS_S = '0,
    parameter logic signed [CW-1:0] C_ONLY   = '0,
    parameter logic signed [CW-1:0] C_MIN_S  = '0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2*W-1:0]   IN_DATA,
    input  logic [2:0]       IN_SEL,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [2*W-1:0]   OUT_DATA,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             OVF,
    input  logic             OVF_CLR
);
    localparam int unsigned PW = W + CW + 1;
    localparam int unsigned AW = PW + 1;
    localparam logic signed [AW-1:0] RND  = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    // Returns {ovf, -a}; the most negative code saturates to the most positive one.
    function automatic logic [W:0] neg_sat(input logic [W-1:0] a);
        logic [W:0] r;
        if (a == {1'b1, {(W-1){1'b0}}}) r = {1'b1, 1'b0, {(W-1){1'b1}}};
        else                            r = {1'b0, -a};
        return r;
    endfunction

    function automatic logic [W:0] sat(input logic signed [AW-1:0] a);
        logic [W:0] r;
        if (a > SMAX)      r = {1'b1, SMAX[W-1:0]};
        else if (a < SMIN) r = {1'b1, SMIN[W-1:0]};
        else               r = {1'b0, a[W-1:0]};
        return r;
    endfunction

    logic                    ld1, ld2, ld3, ld4;
    logic                    vld1_q, vld2_q, vld3_q, vld4_q;
    logic signed [W-1:0]     x1_q, y1_q, x1_d, y1_d;
    logic signed [W:0]       p1_q, p1_d;
    logic                    nr1_q, ni1_q, ovf1_q, nr1_d, ni1_d, ovf1_d;
    logic [TAG_W-1:0]        tag1_q, tag2_q, tag3_q, tag4_q;
    logic signed [PW-1:0]    t2_q, u2_q, v2_q, t2_d, u2_d, v2_d;
    logic                    nr2_q, ni2_q, ovf2_q;
    logic signed [W-1:0]     re3_q, im3_q, re3_d, im3_d;
    logic                    nr3_q, ni3_q, ovf3_q, ovf3_d;
    logic [2*W-1:0]          data4_q, data4_d;
    logic                    ovf4_d, ovf_q;
    logic [W-1:0]            ar, ai, xs, ys;
    logic [W:0]              xn, yn, re_s, im_s, rn, in_n;
    logic signed [AW-1:0]    re_w, im_w, re_r, im_r;

    // A stage advances when empty or when the stage after it advances.
    always_comb begin
        ld4      = ~vld4_q | OUT_READY;
        ld3      = ~vld3_q | ld4;
        ld2      = ~vld2_q | ld3;
        ld1      = ~vld1_q | ld2;
        IN_READY = ld1;
    end

    always_comb begin
        ar     = IN_DATA[2*W-1:W];
        ai     = IN_DATA[W-1:0];
        xs     = IN_SEL[2] ? ai : ar;
        ys     = IN_SEL[2] ? ar : ai;
        xn     = neg_sat(xs);
        yn     = neg_sat(ys);
        x1_d   = IN_SEL[1] ? xn[W-1:0] : xs;
        y1_d   = IN_SEL[0] ? yn[W-1:0] : ys;
        ovf1_d = (IN_SEL[1] & xn[W]) | (IN_SEL[0] & yn[W]);
        p1_d   = {x1_d[W-1], x1_d} + {y1_d[W-1], y1_d};
        nr1_d  = IN_SEL[2] & (IN_SEL[1] ^ IN_SEL[0]);
        ni1_d  = ~IN_SEL[2] & (IN_SEL[1] ^ IN_SEL[0]);
    end

    always_comb begin
        t2_d = PW'(p1_q) * PW'(C_ONLY);
        u2_d = PW'(y1_q) * PW'(C_MIN_S);
        v2_d = PW'(x1_q) * PW'(C_PLUS_S);
    end

    // t - u = C*x + S*y and t - v = C*y - S*x; round half-up before saturating.
    always_comb begin
        re_w   = AW'(t2_q) - AW'(u2_q);
        im_w   = AW'(t2_q) - AW'(v2_q);
        re_r   = (re_w + RND) >>> FRAC;
        im_r   = (im_w + RND) >>> FRAC;
        re_s   = sat(re_r);
        im_s   = sat(im_r);
        re3_d  = re_s[W-1:0];
        im3_d  = im_s[W-1:0];
        ovf3_d = ovf2_q | re_s[W] | im_s[W];
    end

    always_comb begin
        rn      = neg_sat(re3_q);
        in_n    = neg_sat(im3_q);
        data4_d = {(nr3_q ? rn[W-1:0] : re3_q), (ni3_q ? in_n[W-1:0] : im3_q)};
        ovf4_d  = ovf3_q | (nr3_q & rn[W]) | (ni3_q & in_n[W]);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld1_q <= 1'b0; vld2_q <= 1'b0; vld3_q <= 1'b0; vld4_q <= 1'b0;
            x1_q   <= '0;   y1_q   <= '0;   p1_q   <= '0;
            nr1_q  <= 1'b0; ni1_q  <= 1'b0; ovf1_q <= 1'b0; tag1_q <= '0;
            t2_q   <= '0;   u2_q   <= '0;   v2_q   <= '0;
            nr2_q  <= 1'b0; ni2_q  <= 1'b0; ovf2_q <= 1'b0; tag2_q <= '0;
            re3_q  <= '0;   im3_q  <= '0;
            nr3_q  <= 1'b0; ni3_q  <= 1'b0; ovf3_q <= 1'b0; tag3_q <= '0;
            data4_q <= '0;  tag4_q <= '0;   ovf_q  <= 1'b0;
        end else begin
            if (ld1) vld1_q <= IN_VALID;
            if (ld2) vld2_q <= vld1_q;
            if (ld3) vld3_q <= vld2_q;
            if (ld4) vld4_q <= vld3_q;
            if (ld1 && IN_VALID) begin
                x1_q  <= x1_d;  y1_q  <= y1_d;  p1_q   <= p1_d;
                nr1_q <= nr1_d; ni1_q <= ni1_d; ovf1_q <= ovf1_d; tag1_q <= IN_TAG;
            end
            if (ld2 && vld1_q) begin
                t2_q  <= t2_d;  u2_q  <= u2_d;  v2_q   <= v2_d;
                nr2_q <= nr1_q; ni2_q <= ni1_q; ovf2_q <= ovf1_q; tag2_q <= tag1_q;
            end
            if (ld3 && vld2_q) begin
                re3_q <= re3_d; im3_q <= im3_d;
                nr3_q <= nr2_q; ni3_q <= ni2_q; ovf3_q <= ovf3_d; tag3_q <= tag2_q;
            end
            if (ld4 && vld3_q) begin
                data4_q <= data4_d;
                tag4_q  <= tag3_q;
            end
            if (OVF_CLR)                           ovf_q <= 1'b0;
            else if (ld4 && vld3_q && ovf4_d)      ovf_q <= 1'b1;
        end
    end

    assign OUT_VALID = vld4_q;
    assign OUT_DATA  = data4_q;
    assign OUT_TAG   = tag4_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_pipelined_twiddle_mult_stream.sv
// Directed and randomised checks of the twiddle rotator: pi/8 twiddle instance plus a unity-
// coefficient instance for saturation corners.
module tb_pipelined_twiddle_mult_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        in_valid, in_ready, out_valid, out_ready, ovf, ovf_clr;
    logic [31:0] in_data, out_data;
    logic [2:0]  in_sel;
    logic [5:0]  in_tag, out_tag;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf, b_ovf_clr;
    logic [31:0] b_in_data, b_out_data;
    logic [2:0]  b_in_sel;
    logic [5:0]  b_in_tag, b_out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    pipelined_twiddle_mult_stream #(
        .W(16), .CW(16), .FRAC(14), .TAG_W(6),
        .C_PLUS_S(16'sd21407), .C_ONLY(16'sd15137), .C_MIN_S(16'sd8867)
    ) dut_a (
        .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .IN_SEL(in_sel), .IN_TAG(in_tag), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_DATA(out_data), .OUT_TAG(out_tag), .OVF(ovf), .OVF_CLR(ovf_clr)
    );

    pipelined_twiddle_mult_stream #(
        .W(16), .CW(16), .FRAC(14), .TAG_W(6),
        .C_PLUS_S(16'sd16384), .C_ONLY(16'sd16384), .C_MIN_S(16'sd16384)
    ) dut_b (
        .CLK(clk), .RSTN(rstn), .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_DATA(b_in_data),
        .IN_SEL(b_in_sel), .IN_TAG(b_in_tag), .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready),
        .OUT_DATA(b_out_data), .OUT_TAG(b_out_tag), .OVF(b_ovf), .OVF_CLR(b_ovf_clr)
    );

    function automatic logic [31:0] cpx(input int r, input int i);
        return {16'(r), 16'(i)};
    endfunction

    // Direct complex rotation by C - jS with octant folding, written as the mathematical product.
    function automatic logic [31:0] model(input logic [31:0] d, input logic [2:0] s, output bit o);
        longint ar, ai, x, y, re, im;
        o  = 1'b0;
        ar = longint'($signed(d[31:16]));
        ai = longint'($signed(d[15:0]));
        x  = s[2] ? ai : ar;
        y  = s[2] ? ar : ai;
        if (s[1]) begin x = -x; if (x > 32767) begin x = 32767; o = 1'b1; end end
        if (s[0]) begin y = -y; if (y > 32767) begin y = 32767; o = 1'b1; end end
        re = (15137 * x + 6270 * y + 8192) >>> 14;
        im = (15137 * y - 6270 * x + 8192) >>> 14;
        if (re > 32767) begin re = 32767; o = 1'b1; end else if (re < -32768) begin re = -32768; o = 1'b1; end
        if (im > 32767) begin im = 32767; o = 1'b1; end else if (im < -32768) begin im = -32768; o = 1'b1; end
        if (s[2] && (s[1] ^ s[0])) begin re = -re; if (re > 32767) begin re = 32767; o = 1'b1; end end
        if (!s[2] && (s[1] ^ s[0])) begin im = -im; if (im > 32767) begin im = 32767; o = 1'b1; end end
        return {16'(re), 16'(im)};
    endfunction

    task automatic run_single(input logic [31:0] d, input logic [2:0] s, input logic [5:0] t, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sel = s; in_tag = t; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; in_tag = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_in_tag = '0; b_out_ready = 1'b0; b_ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_tests++; if (out_tag !== 6'h0) begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_tests++; if (b_out_valid !== 1'b0 || b_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_b: valid %b ovf %b want 0 0", b_out_valid, b_ovf); end
        rstn = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_latency();
        int lat;
        run_single(cpx(16384, 0), 3'b000, 6'd5, lat);
        n_tests++; if (lat != 4) begin n_fail++; $display("FAIL t1_latency: got %0d want 4", lat); end
        n_tests++; if (out_data !== cpx(15137, -6270)) begin n_fail++; $display("FAIL t1_data: got %h want %h", out_data, cpx(15137, -6270)); end
        n_tests++; if (out_tag !== 6'd5) begin n_fail++; $display("FAIL t1_tag: got %0d want 5", out_tag); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL t1_ovf: got %b want 0", ovf); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_no_dup: got valid %b want 0", out_valid); end
    endtask

    task automatic test_octants();
        logic [31:0] exp_d [8];
        int lat;
        exp_d[0] = cpx(15137, -6270);  exp_d[1] = cpx(15137, 6270);
        exp_d[2] = cpx(-15137, -6270); exp_d[3] = cpx(-15137, 6270);
        exp_d[4] = cpx(6270, 15137);   exp_d[5] = cpx(6270, -15137);
        exp_d[6] = cpx(-6270, 15137);  exp_d[7] = cpx(-6270, -15137);
        for (int k = 0; k < 8; k++) begin
            run_single(cpx(16384, 0), 3'(k), 6'(k + 10), lat);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_tag !== 6'(k + 10)) begin
                n_fail++;
                $display("FAIL octant_sel%0d: got v%b %h tag %0d want v1 %h tag %0d", k, out_valid, out_data, out_tag, exp_d[k], k + 10);
            end
        end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL octant_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_saturation();
        int lat;
        logic [31:0] d [2];
        logic [2:0]  s [2];
        logic [31:0] e [2];
        logic        eo [2];
        d[0] = cpx(-32768, -32768); s[0] = 3'b000; e[0] = cpx(-32768, -32768); eo[0] = 1'b0;
        d[1] = cpx(-32768, -32768); s[1] = 3'b011; e[1] = cpx(32767, 32767);   eo[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            b_in_valid = 1'b1; b_in_data = d[k]; b_in_sel = s[k]; b_in_tag = 6'(k); b_out_ready = 1'b1;
            @(negedge clk);
            b_in_valid = 1'b0;
            lat = 1;
            while (b_out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
            n_tests++; if (b_out_data !== e[k]) begin n_fail++; $display("FAIL sat_data%0d: got %h want %h", k, b_out_data, e[k]); end
            n_tests++; if (b_ovf !== eo[k]) begin n_fail++; $display("FAIL sat_ovf%0d: got %b want %b", k, b_ovf, eo[k]); end
        end
        @(negedge clk); b_ovf_clr = 1'b1;
        @(negedge clk); b_ovf_clr = 1'b0;
        n_tests++; if (b_ovf !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %b want 0", b_ovf); end
        @(negedge clk);
        n_tests++; if (b_ovf !== 1'b0) begin n_fail++; $display("FAIL sat_clear_hold: got %b want 0", b_ovf); end
    endtask

    task automatic test_clear_priority();
        int lat;
        @(negedge clk);
        b_ovf_clr = 1'b1;
        b_in_valid = 1'b1; b_in_data = cpx(-32768, -32768); b_in_sel = 3'b011; b_in_tag = 6'd9; b_out_ready = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 1;
        while (b_out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        n_tests++; if (b_out_valid !== 1'b1 || b_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_wins: got valid %b ovf %b want 1 0", b_out_valid, b_ovf); end
        b_ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (b_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_no_phantom: got %b want 0", b_ovf); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [8];
        logic [2:0]  s [8];
        logic [31:0] e [8];
        int acc, got, cyc, acc_at8;
        d[0] = cpx(16384, 0);     s[0] = 3'b000; e[0] = cpx(15137, -6270);
        d[1] = cpx(16384, 0);     s[1] = 3'b100; e[1] = cpx(6270, 15137);
        d[2] = cpx(16384, 0);     s[2] = 3'b010; e[2] = cpx(-15137, -6270);
        d[3] = cpx(-8192, -8192); s[3] = 3'b000; e[3] = cpx(-10703, -4433);
        d[4] = cpx(0, 16384);     s[4] = 3'b001; e[4] = cpx(-6270, 15137);
        d[5] = cpx(16384, 0);     s[5] = 3'b110; e[5] = cpx(-6270, 15137);
        d[6] = cpx(8192, 8192);   s[6] = 3'b000; e[6] = cpx(10704, 4434);
        d[7] = cpx(-16384, 0);    s[7] = 3'b000; e[7] = cpx(-15137, 6270);
        acc = 0; got = 0; cyc = 0; acc_at8 = -1;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 12);
            in_valid  = (acc < 8);
            if (acc < 8) begin in_data = d[acc]; in_sel = s[acc]; in_tag = 6'(acc); end
            #1;
            if (cyc == 8) begin
                acc_at8 = acc;
                n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b want 0", in_ready); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_tests++;
                if (out_tag !== 6'(got) || out_data !== e[got]) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d: got tag %0d %h want tag %0d %h", got, out_tag, out_data, got, e[got]);
                end
                got++;
            end
            if (in_valid && in_ready === 1'b1) acc++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++; if (acc_at8 != 4) begin n_fail++; $display("FAIL b2b_capacity: got %0d accepted want 4", acc_at8); end
        n_tests++; if (got != 8) begin n_fail++; $display("FAIL b2b_drain: got %0d beats want 8", got); end
    endtask

    task automatic test_random();
        localparam int N = 2000;
        logic [37:0] exp_q [$];
        logic [37:0] front;
        logic [31:0] cur_d, prev_d, m;
        logic [2:0]  cur_s;
        logic [5:0]  prev_t;
        logic [15:0] cr, ci;
        bit have, stalled, o, exp_ovf;
        int sent, got, cyc;
        @(negedge clk); ovf_clr = 1'b1; in_valid = 1'b0;
        @(negedge clk); ovf_clr = 1'b0;
        have = 0; stalled = 0; exp_ovf = 0; sent = 0; got = 0; cyc = 0;
        prev_d = '0; prev_t = '0; cur_d = '0; cur_s = '0;
        while (got < N && cyc < 20 * N) begin
            @(negedge clk);
            if (!have && sent < N && $urandom_range(0, 3) != 0) begin
                cr = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                ci = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                cur_d = {cr, ci};
                cur_s = 3'($urandom_range(0, 7));
                have = 1;
            end
            in_valid = have; in_data = cur_d; in_sel = cur_s; in_tag = 6'(sent);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (stalled) begin
                n_tests++;
                if ({out_valid, out_tag, out_data} !== {1'b1, prev_t, prev_d}) begin
                    n_fail++;
                    $display("FAIL rand_stall_stable: got v%b tag %0d %h want v1 tag %0d %h", out_valid, out_tag, out_data, prev_t, prev_d);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra_beat: got tag %0d %h want none", out_tag, out_data);
                end else begin
                    front = exp_q.pop_front();
                    if ({out_tag, out_data} !== front) begin
                        n_fail++;
                        $display("FAIL rand_beat%0d: got tag %0d %h want tag %0d %h", got, out_tag, out_data, front[37:32], front[31:0]);
                    end
                end
                got++;
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            prev_d = out_data; prev_t = out_tag;
            if (in_valid && in_ready === 1'b1) begin
                m = model(cur_d, cur_s, o);
                exp_q.push_back({6'(sent), m});
                exp_ovf |= o;
                sent++; have = 0;
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++; if (got != N) begin n_fail++; $display("FAIL rand_drain: got %0d beats want %0d", got, N); end
        n_tests++; if (ovf !== exp_ovf) begin n_fail++; $display("FAIL rand_ovf: got %b want %b", ovf, exp_ovf); end
    endtask

    task automatic test_reset_flush();
        logic [31:0] d [3];
        logic [2:0]  s [3];
        int seen;
        d[0] = cpx(-32768, 0); s[0] = 3'b010;
        d[1] = cpx(16384, 0);  s[1] = 3'b000;
        d[2] = cpx(0, 16384);  s[2] = 3'b000;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = d[k]; in_sel = s[k]; in_tag = 6'(k + 40);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL flush_ovf: got %b want 0", ovf); end
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL flush_stale: got %0d valid cycles want 0", seen); end
        n_tests++; if (ovf !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after: got ovf %b ready %b want 0 1", ovf, in_ready); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_octants();
        test_saturation();
        test_clear_priority();
        test_back_to_back();
        test_random();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
